pulse_gen: RTL and testbench

Pin-drive pulse generator, the transmit-side counterpart of the input delay/debounce filter. Single-cycle trigger requests are turned into clean high pulses on an output pin. Each pulse has a programmable width and is followed by a guaranteed minimum low gap, so a downstream input filter with counter size N always sees a stable level. Triggers that arrive while a pulse or gap is in progress are counted and replayed in order. Triggers beyond the pending capacity are dropped and flagged.

---
 rtl/pulse_gen.sv | 122 ++++++++++++
 tb/tb_pulse_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_gen.sv
// pulse_gen: pin-drive pulse generator.
// Each single-cycle trigger request becomes a high pulse of len+1 clocks,
// followed by a low gap of exactly G clocks. Triggers arriving during a
// pulse or gap are counted (up to 2^P-1) and replayed in order; triggers
// beyond that capacity are dropped and flagged on ovf.
//
// Ports:
//   clk   system clock, all logic on posedge
//   rst   synchronous active-high reset
//   trig  pulse request, one request per high cycle
//   len   pulse width minus one, sampled when a pulse starts
//   pout  registered pin drive
//   busy  high whenever the FSM is not idle
//   done  registered one-cycle strobe in the first low cycle after a pulse
//   pend  number of queued, not-yet-started triggers
//   ovf   registered one-cycle strobe when a trigger is dropped
module pulse_gen #(
  parameter int unsigned N = 4,
  parameter int unsigned G = 4,
  parameter int unsigned P = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         trig,
  input  logic [N-1:0] len,
  output logic         pout,
  output logic         busy,
  output logic         done,
  output logic [P-1:0] pend,
  output logic         ovf
);

  localparam int unsigned GW = (G > 1) ? $clog2(G) : 1;

  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

  state_t         state, state_n;
  logic [N-1:0]   cnt, cnt_n;
  logic [GW-1:0]  gcnt, gcnt_n;
  logic           pout_n, done_n, ovf_n;
  logic [P-1:0]   pend_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      gcnt  <= '0;
      pout  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
      pend  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      gcnt  <= gcnt_n;
      pout  <= pout_n;
      done  <= done_n;
      ovf   <= ovf_n;
      pend  <= pend_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    gcnt_n  = gcnt;
    pout_n  = pout;
    done_n  = 1'b0;
    ovf_n   = 1'b0;
    pend_n  = pend;

    unique case (state)
      IDLE: begin
        if (trig) begin
          state_n = HIGH;
          pout_n  = 1'b1;
          cnt_n   = len;
        end
      end

      HIGH: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          state_n = GAP;
          pout_n  = 1'b0;
          gcnt_n  = GW'(G - 1);
          done_n  = 1'b1;
        end
        if (trig) begin
          if (pend != '1) pend_n = pend + 1'b1;
          else            ovf_n  = 1'b1;
        end
      end

      GAP: begin
        if (gcnt != '0) begin
          gcnt_n = gcnt - 1'b1;
          if (trig) begin
            if (pend != '1) pend_n = pend + 1'b1;
            else            ovf_n  = 1'b1;
          end
        end else if (pend != '0 || trig) begin
          // Last gap cycle: start the next pulse directly. A queued entry is
          // consumed; a simultaneous trig replaces it (net zero), or is
          // consumed itself when nothing was queued.
          state_n = HIGH;
          pout_n  = 1'b1;
          cnt_n   = len;
          if (pend != '0 && !trig) pend_n = pend - 1'b1;
        end else begin
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_pulse_gen.sv
// Self-checking bench for pulse_gen (N=4, G=4, P=2).
// Cycle k is the interval after the k-th counted rising edge; inputs set in
// cycle k are sampled on the edge that ends it, outputs are sampled 1ns
// after the edge that begins it.
module tb_pulse_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       trig;
  logic [3:0] len;
  logic       pout, busy, done, ovf;
  logic [1:0] pend;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;
  logic pout_prev = 1'b0;

  pulse_gen #(.N(4), .G(4), .P(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .trig (trig),
    .len  (len),
    .pout (pout),
    .busy (busy),
    .done (done),
    .pend (pend),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    bit         first;
    logic       trig;
    logic [3:0] len;
    logic       pout;
    logic       busy;
    logic       done;
    logic       ovf;
    logic [1:0] pend;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(int c, bit f, logic t, logic [3:0] l, logic po,
                             logic bu, logic dn, logic ov, logic [1:0] pe);
    vec_t r;
    r.cyc = c; r.first = f; r.trig = t; r.len = l;
    r.pout = po; r.busy = bu; r.done = dn; r.ovf = ov; r.pend = pe;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (pout && !pout_prev) pulses++;
    pout_prev = pout;
  endtask

  // Two reset cycles with trig held high to show trig is ignored under rst.
  task automatic do_reset();
    rst  = 1'b1;
    trig = 1'b1;
    len  = 4'd0;
    step();
    step();
    rst  = 1'b0;
    trig = 1'b0;
    cyc  = 0;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int p0;
    rst = 1'b1; trig = 1'b0; len = 4'd0;

    // Scenario A: single pulse, len=3, trig at 10.
    tv.push_back(v(10, 1, 1, 3, 0, 0, 0, 0, 0));
    tv.push_back(v(11, 0, 0, 3, 1, 1, 0, 0, 0));
    tv.push_back(v(12, 0, 0, 3, 1, 1, 0, 0, 0));
    tv.push_back(v(13, 0, 0, 3, 1, 1, 0, 0, 0));
    tv.push_back(v(14, 0, 0, 3, 1, 1, 0, 0, 0));
    tv.push_back(v(15, 0, 0, 3, 0, 1, 1, 0, 0));
    tv.push_back(v(16, 0, 0, 3, 0, 1, 0, 0, 0));
    tv.push_back(v(17, 0, 0, 3, 0, 1, 0, 0, 0));
    tv.push_back(v(18, 0, 0, 3, 0, 1, 0, 0, 0));
    tv.push_back(v(19, 0, 0, 3, 0, 0, 0, 0, 0));
    tv.push_back(v(20, 0, 0, 3, 0, 0, 0, 0, 0));
    // Scenario F: same, plus trig on the last gap cycle (18).
    tv.push_back(v(10, 1, 1, 3, 0, 0, 0, 0, 0));
    tv.push_back(v(11, 0, 0, 3, 1, 1, 0, 0, 0));
    tv.push_back(v(14, 0, 0, 3, 1, 1, 0, 0, 0));
    tv.push_back(v(15, 0, 0, 3, 0, 1, 1, 0, 0));
    tv.push_back(v(16, 0, 0, 3, 0, 1, 0, 0, 0));
    tv.push_back(v(17, 0, 0, 3, 0, 1, 0, 0, 0));
    tv.push_back(v(18, 0, 1, 3, 0, 1, 0, 0, 0));
    tv.push_back(v(19, 0, 0, 3, 1, 1, 0, 0, 0));
    tv.push_back(v(20, 0, 0, 3, 1, 1, 0, 0, 0));
    tv.push_back(v(21, 0, 0, 3, 1, 1, 0, 0, 0));
    tv.push_back(v(22, 0, 0, 3, 1, 1, 0, 0, 0));
    tv.push_back(v(23, 0, 0, 3, 0, 1, 1, 0, 0));
    tv.push_back(v(26, 0, 0, 3, 0, 1, 0, 0, 0));
    tv.push_back(v(27, 0, 0, 3, 0, 0, 0, 0, 0));
    // Scenario B: minimum width, len=0.
    tv.push_back(v(10, 1, 1, 0, 0, 0, 0, 0, 0));
    tv.push_back(v(11, 0, 0, 0, 1, 1, 0, 0, 0));
    tv.push_back(v(12, 0, 0, 0, 0, 1, 1, 0, 0));
    tv.push_back(v(13, 0, 0, 0, 0, 1, 0, 0, 0));
    tv.push_back(v(15, 0, 0, 0, 0, 1, 0, 0, 0));
    tv.push_back(v(16, 0, 0, 0, 0, 0, 0, 0, 0));
    // Scenario C: back-to-back, len=1, trig at 10 and 12.
    tv.push_back(v(10, 1, 1, 1, 0, 0, 0, 0, 0));
    tv.push_back(v(11, 0, 0, 1, 1, 1, 0, 0, 0));
    tv.push_back(v(12, 0, 1, 1, 1, 1, 0, 0, 0));
    tv.push_back(v(13, 0, 0, 1, 0, 1, 1, 0, 1));
    tv.push_back(v(14, 0, 0, 1, 0, 1, 0, 0, 1));
    tv.push_back(v(16, 0, 0, 1, 0, 1, 0, 0, 1));
    tv.push_back(v(17, 0, 0, 1, 1, 1, 0, 0, 0));
    tv.push_back(v(18, 0, 0, 1, 1, 1, 0, 0, 0));
    tv.push_back(v(19, 0, 0, 1, 0, 1, 1, 0, 0));
    tv.push_back(v(22, 0, 0, 1, 0, 1, 0, 0, 0));
    tv.push_back(v(23, 0, 0, 1, 0, 0, 0, 0, 0));

    // Reset state.
    do_reset();
    chk("rst_pout", 32'(pout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf",  32'(ovf),  32'd0);
    chk("rst_pend", 32'(pend), 32'd0);

    // Table-driven scenarios; gaps between listed cycles run with trig=0.
    foreach (tv[i]) begin
      if (tv[i].first) begin
        do_reset();
      end
      trig = 1'b0;
      run_to(tv[i].cyc);
      trig = tv[i].trig;
      len  = tv[i].len;
      chk($sformatf("tv%0d_pout", i), 32'(pout), 32'(tv[i].pout));
      chk($sformatf("tv%0d_busy", i), 32'(busy), 32'(tv[i].busy));
      chk($sformatf("tv%0d_done", i), 32'(done), 32'(tv[i].done));
      chk($sformatf("tv%0d_ovf",  i), 32'(ovf),  32'(tv[i].ovf));
      chk($sformatf("tv%0d_pend", i), 32'(pend), 32'(tv[i].pend));
      step();
    end
    trig = 1'b0;

    // Maximum width: len=15 gives 16 high cycles, then done.
    do_reset();
    run_to(20);
    len = 4'd15; trig = 1'b1;
    step();
    trig = 1'b0;
    hi = 0;
    while (pout && hi < 40) begin
      hi++;
      step();
    end
    chk("maxw_width", 32'(hi), 32'd16);
    chk("maxw_done",  32'(done), 32'd1);

    // Overflow: len=7, trig at 10, then 12..15.
    do_reset();
    pulses = 0; pout_prev = 1'b0;
    run_to(10);
    len = 4'd7; trig = 1'b1;
    step();
    trig = 1'b0;
    step();
    for (int c = 12; c <= 15; c++) begin
      trig = 1'b1;
      step();
      chk($sformatf("ovf_pend_c%0d", c + 1), 32'(pend), 32'((c - 11 > 3) ? 3 : c - 11));
      chk($sformatf("ovf_ovf_c%0d",  c + 1), 32'(ovf),  32'((c == 15) ? 1 : 0));
    end
    trig = 1'b0;
    step();
    chk("ovf_ovf_c17",  32'(ovf),  32'd0);
    chk("ovf_pend_c17", 32'(pend), 32'd3);
    run_to(80);
    chk("ovf_pulses", 32'(pulses), 32'd4);
    chk("ovf_idle",   32'(busy),   32'd0);
    chk("ovf_pend_end", 32'(pend), 32'd0);

    // Reset mid-pulse with pend=2 and trig high.
    do_reset();
    run_to(10);
    len = 4'd15; trig = 1'b1;
    step();
    trig = 1'b0;
    step();
    trig = 1'b1;
    step();
    step();
    trig = 1'b0;
    run_to(20);
    chk("mrst_pre_pout", 32'(pout), 32'd1);
    chk("mrst_pre_pend", 32'(pend), 32'd2);
    rst = 1'b1; trig = 1'b1;
    step();
    rst = 1'b0; trig = 1'b0;
    chk("mrst_pout", 32'(pout), 32'd0);
    chk("mrst_pend", 32'(pend), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    p0 = pulses;
    run_to(60);
    chk("mrst_no_pulses", 32'(pulses - p0), 32'd0);
    chk("mrst_busy_end",  32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
